obstacle_speed_scheduler: RTL and testbench

- Sequences horizontal scrolling of the obstacle datapath.
- Converts the 60 Hz game tick into a move strobe plus a step size, using a fractional speed accumulator.
- Raises difficulty level over time during a run.
- Gates scrolling by game phase (idle / run / over).
- Sits between the graphics tick generator and player controller pulses (upstream) and the obstacle movement logic (downstream).

---
 rtl/obstacle_speed_scheduler_pkg.sv | 39 +++
 rtl/obstacle_speed_scheduler_if.sv | 54 +++++
 rtl/obstacle_speed_scheduler_speed_accumulator.sv | 61 ++++++
 rtl/obstacle_speed_scheduler.sv | 147 ++++++++++++++
 tb/tb_obstacle_speed_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obstacle_speed_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_sched_pkg
// Shared definitions for the obstacle scroll scheduler:
//   - scheduler state encoding (IDLE/RUN/OVER/PAUSE)
//   - accumulator geometry (6-bit accumulator, 4 fraction bits)
//   - default speed / timing constants
//   - calc_speed(): speed for a given difficulty level
// -----------------------------------------------------------------------------
package obstacle_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_OVER  = 2'd2,
    ST_PAUSE = 2'd3
  } sched_state_t;

  // Speed accumulator geometry: the low FRAC_W bits are sub-pixel fraction,
  // the remaining bits are whole pixels to move on this tick.
  localparam int ACC_W   = 6;
  localparam int FRAC_W  = 4;
  localparam int STEP_W  = ACC_W - FRAC_W;
  localparam int LEVEL_W = 3;
  localparam int LCNT_W  = 10;

  localparam int DEF_BASE_SPEED  = 8;
  localparam int DEF_SPEED_INC   = 2;
  localparam int DEF_MAX_LEVEL   = 7;
  localparam int DEF_LEVEL_TICKS = 600;
  localparam int DEF_OVER_HOLD   = 120;

  // Speed in 1/16 pixel per game tick for a given level.
  function automatic logic [ACC_W-1:0] calc_speed(input logic [LEVEL_W-1:0] lvl,
                                                  input int base,
                                                  input int inc);
    return ACC_W'(base + int'(lvl) * inc);
  endfunction

endpackage

// File: rtl/obstacle_speed_scheduler_if.sv
// -----------------------------------------------------------------------------
// obstacle_speed_scheduler_if
// Groups the scheduler's control inputs and scroll outputs.
//   master : game/controller side (drives pulses, observes scroll outputs)
//   slave  : the scheduler itself
// Signals:
//   game_tick, game_start_pulse, game_over_pulse : one-clk input pulses
//   pause_toggle (only with OBSTACLE_SCHED_PAUSE_EN) : one-clk input pulse
//   move_pulse, move_step, level, scroll_en, sched_state : scheduler outputs
// -----------------------------------------------------------------------------
interface obstacle_speed_scheduler_if;
  import obstacle_sched_pkg::*;

  logic               game_tick;
  logic               game_start_pulse;
  logic               game_over_pulse;
`ifdef OBSTACLE_SCHED_PAUSE_EN
  logic               pause_toggle;
`endif
  logic               move_pulse;
  logic [STEP_W-1:0]  move_step;
  logic [LEVEL_W-1:0] level;
  logic               scroll_en;
  logic [1:0]         sched_state;

  modport master (
    output game_tick,
    output game_start_pulse,
    output game_over_pulse,
`ifdef OBSTACLE_SCHED_PAUSE_EN
    output pause_toggle,
`endif
    input  move_pulse,
    input  move_step,
    input  level,
    input  scroll_en,
    input  sched_state
  );

  modport slave (
    input  game_tick,
    input  game_start_pulse,
    input  game_over_pulse,
`ifdef OBSTACLE_SCHED_PAUSE_EN
    input  pause_toggle,
`endif
    output move_pulse,
    output move_step,
    output level,
    output scroll_en,
    output sched_state
  );

endinterface

// File: rtl/obstacle_speed_scheduler_speed_accumulator.sv
// -----------------------------------------------------------------------------
// speed_accumulator
// Fractional speed accumulator. Each enabled tick adds speed to the
// accumulator; whenever the sum reaches one whole pixel the whole-pixel part
// is emitted as move_step with a one-clk move_pulse and only the fraction is
// kept.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick_en     : accumulate this cycle (qualified game tick)
//   clear       : zero the accumulator (start of a run)
//   speed       : increment in 1/16 pixel
//   move_pulse  : one-clk strobe, one clk after the qualifying tick
//   move_step   : whole pixels to move, held until the next pulse
// -----------------------------------------------------------------------------
module speed_accumulator
  import obstacle_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic              clear,
  input  logic [ACC_W-1:0]  speed,
  output logic              move_pulse,
  output logic [STEP_W-1:0] move_step
);

  logic [ACC_W-1:0]  r_acc;
  logic              r_move_pulse;
  logic [STEP_W-1:0] r_move_step;
  logic [ACC_W-1:0]  w_sum;
  logic              w_whole;

  // acc < 16 and speed <= 22 at the defaults, so the sum never wraps 6 bits.
  assign w_sum   = r_acc + speed;
  assign w_whole = |w_sum[ACC_W-1:FRAC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_move_pulse <= 1'b0;
      r_move_step  <= '0;
    end else begin
      r_move_pulse <= 1'b0;
      if (clear) begin
        r_acc <= '0;
      end else if (tick_en) begin
        if (w_whole) begin
          r_move_pulse <= 1'b1;
          r_move_step  <= w_sum[ACC_W-1:FRAC_W];
          r_acc        <= {{STEP_W{1'b0}}, w_sum[FRAC_W-1:0]};
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign move_pulse = r_move_pulse;
  assign move_step  = r_move_step;

endmodule

// File: rtl/obstacle_speed_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_speed_scheduler
// Turns the 60 Hz game tick into obstacle move strobes, raises the difficulty
// level during a run and gates scrolling by game phase.
// Optional feature macro: OBSTACLE_SCHED_PAUSE_EN (adds pause_toggle and the
// PAUSE state; without it PAUSE is unreachable).
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : obstacle_speed_scheduler_if.slave
//            in : game_tick, game_start_pulse, game_over_pulse, [pause_toggle]
//            out: move_pulse, move_step, level, scroll_en, sched_state
// -----------------------------------------------------------------------------
module obstacle_speed_scheduler
  import obstacle_sched_pkg::*;
#(
  parameter int BASE_SPEED  = DEF_BASE_SPEED,
  parameter int SPEED_INC   = DEF_SPEED_INC,
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int LEVEL_TICKS = DEF_LEVEL_TICKS,
  parameter int OVER_HOLD   = DEF_OVER_HOLD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  obstacle_speed_scheduler_if.slave   bus
);

  localparam int HOLD_W = $clog2(OVER_HOLD + 1);

  sched_state_t        r_state, w_state_next;
  logic [LEVEL_W-1:0]  r_level, w_level_next;
  logic [LCNT_W-1:0]   r_lcnt, w_lcnt_next;
  logic [HOLD_W-1:0]   r_hold, w_hold_next;
  logic                r_scroll_en;
  logic                w_acc_tick;
  logic                w_acc_clear;
  logic                w_pause;
  logic [ACC_W-1:0]    w_speed;

`ifdef OBSTACLE_SCHED_PAUSE_EN
  assign w_pause = bus.pause_toggle;
`else
  assign w_pause = 1'b0;
`endif

  // Registered level means a level bump takes effect on the following tick.
  assign w_speed = calc_speed(r_level, BASE_SPEED, SPEED_INC);

  // Next-state / counter logic. Pulse priority: over > start > pause > tick;
  // a tick arriving with a state-changing pulse is dropped.
  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level;
    w_lcnt_next  = r_lcnt;
    w_hold_next  = r_hold;
    w_acc_tick   = 1'b0;
    w_acc_clear  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.game_start_pulse && !bus.game_over_pulse) begin
          w_state_next = ST_RUN;
          w_acc_clear  = 1'b1;
          w_level_next = '0;
          w_lcnt_next  = '0;
        end
      end
      ST_RUN: begin
        if (bus.game_over_pulse) begin
          w_state_next = ST_OVER;
          w_hold_next  = '0;
        end else if (w_pause) begin
          w_state_next = ST_PAUSE;
        end else if (bus.game_tick) begin
          w_acc_tick = 1'b1;
          if (r_lcnt == LCNT_W'(LEVEL_TICKS - 1)) begin
            w_lcnt_next = '0;
            if (r_level != LEVEL_W'(MAX_LEVEL)) begin
              w_level_next = r_level + 1'b1;
            end
          end else begin
            w_lcnt_next = r_lcnt + 1'b1;
          end
        end
      end
      ST_OVER: begin
        // A repeated crash pulse while already over is a no-op that still
        // outranks start.
        if (!bus.game_over_pulse) begin
          if (bus.game_start_pulse) begin
            w_state_next = ST_RUN;
            w_acc_clear  = 1'b1;
            w_level_next = '0;
            w_lcnt_next  = '0;
          end else if (bus.game_tick) begin
            if (r_hold == HOLD_W'(OVER_HOLD - 1)) begin
              w_state_next = ST_IDLE;
            end else begin
              w_hold_next = r_hold + 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (bus.game_over_pulse) begin
          w_state_next = ST_OVER;
          w_hold_next  = '0;
        end else if (w_pause) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_level     <= '0;
      r_lcnt      <= '0;
      r_hold      <= '0;
      r_scroll_en <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_level     <= w_level_next;
      r_lcnt      <= w_lcnt_next;
      r_hold      <= w_hold_next;
      r_scroll_en <= (w_state_next == ST_RUN);
    end
  end

  speed_accumulator u_speed_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_en    (w_acc_tick),
    .clear      (w_acc_clear),
    .speed      (w_speed),
    .move_pulse (bus.move_pulse),
    .move_step  (bus.move_step)
  );

  assign bus.level       = r_level;
  assign bus.scroll_en   = r_scroll_en;
  assign bus.sched_state = r_state;

endmodule

// File: tb/tb_obstacle_speed_scheduler.sv
// -----------------------------------------------------------------------------
// tb_obstacle_speed_scheduler
// Directed stimulus; a reference model pushes every expected move (cycle and
// step) into a scoreboard queue, and a separate monitor pops and compares on
// each observed move_pulse. Phase outputs are checked at chosen points.
// -----------------------------------------------------------------------------
module tb_obstacle_speed_scheduler;
  import obstacle_sched_pkg::*;

  localparam int LT = 600;
  localparam int OH = 120;
  localparam int BS = 8;
  localparam int SI = 2;
  localparam int ML = 7;
`ifdef OBSTACLE_SCHED_PAUSE_EN
  localparam bit HAS_PAUSE = 1'b1;
`else
  localparam bit HAS_PAUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obstacle_speed_scheduler_if bus ();

  obstacle_speed_scheduler #(
    .BASE_SPEED  (BS),
    .SPEED_INC   (SI),
    .MAX_LEVEL   (ML),
    .LEVEL_TICKS (LT),
    .OVER_HOLD   (OH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int step;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   seen_moves = 0;

  // reference model state
  int m_state = 0;
  int m_acc = 0;
  int m_level = 0;
  int m_lcnt = 0;
  int m_hold = 0;
  bit m_pushed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every move strobe must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.move_pulse === 1'b1) begin
      seen_moves++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_move actual=step%0d@cyc%0d required=no_move", bus.move_step, cyc);
      end else begin
        e = sb_q.pop_front();
        check("move_cycle", cyc, e.cyc);
        check("move_step", int'(bus.move_step), e.step);
      end
    end
  end

  task automatic model_reset();
    m_state = 0; m_acc = 0; m_level = 0; m_lcnt = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit o, input bit p);
    int sum;
    exp_t e;
    m_pushed = 1'b0;
    case (m_state)
      0: if (s && !o) begin
           m_state = 1; m_acc = 0; m_level = 0; m_lcnt = 0;
         end
      1: if (o) begin
           m_state = 2; m_hold = 0;
         end else if (p && HAS_PAUSE) begin
           m_state = 3;
         end else if (t) begin
           sum = m_acc + BS + SI * m_level;
           if (sum >= 16) begin
             e.cyc = cyc + 1;
             e.step = sum / 16;
             sb_q.push_back(e);
             m_pushed = 1'b1;
             m_acc = sum % 16;
           end else begin
             m_acc = sum;
           end
           m_lcnt++;
           if (m_lcnt == LT) begin
             m_lcnt = 0;
             if (m_level < ML) m_level++;
           end
         end
      2: if (!o) begin
           if (s) begin
             m_state = 1; m_acc = 0; m_level = 0; m_lcnt = 0;
           end else if (t) begin
             m_hold++;
             if (m_hold == OH) m_state = 0;
           end
         end
      default: if (o) begin
                 m_state = 2; m_hold = 0;
               end else if (p) begin
                 m_state = 1;
               end
    endcase
  endtask

  // One clock of stimulus: inputs change on the falling edge.
  task automatic drive(input bit t, input bit s, input bit o, input bit p);
    @(negedge clk);
    bus.game_tick        = t;
    bus.game_start_pulse = s;
    bus.game_over_pulse  = o;
`ifdef OBSTACLE_SCHED_PAUSE_EN
    bus.pause_toggle     = p;
`endif
    model_step(t, s, o, p);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Call right after drive(): samples just after the edge that applied it.
  task automatic check_state(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_state"}, int'(bus.sched_state), m_state);
    check({tag, "_level"}, int'(bus.level), m_level);
    check({tag, "_scroll_en"}, int'(bus.scroll_en), (m_state == 1) ? 1 : 0);
  endtask

  task automatic drain(input string tag);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_pending_moves"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin : stim
    int base_moves;
    bus.game_tick = 1'b0;
    bus.game_start_pulse = 1'b0;
    bus.game_over_pulse = 1'b0;
`ifdef OBSTACLE_SCHED_PAUSE_EN
    bus.pause_toggle = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", int'(bus.sched_state), 0);
    check("rst_level", int'(bus.level), 0);
    check("rst_scroll_en", int'(bus.scroll_en), 0);
    check("rst_move_pulse", int'(bus.move_pulse), 0);
    check("rst_move_step", int'(bus.move_step), 0);
    rst_n = 1'b1;

    // ticks while idle: no moves
    tick_n(3);
    drain("idle_ticks");

    // level 0: moves after ticks 2 and 4, step 1
    base_moves = seen_moves;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check_state("start");
    tick_n(4);
    drain("lvl0");
    check("lvl0_move_count", seen_moves - base_moves, 2);
    check("lvl0_step", int'(bus.move_step), 1);

    // run up to level 7, then check saturation
    tick_n(7 * LT - 4);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("lvl7");
    check("lvl7_hand", int'(bus.level), 7);
    tick_n(3);
    drain("lvl7_steps");
    tick_n(LT);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("lvl_sat");
    drain("lvl_sat");

    // start together with over in RUN -> OVER, level held
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_state("over");
    tick_n(OH - 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("hold_119");
    check("hold_level_hand", int'(bus.level), 7);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_state("hold_120");
    check("auto_idle_hand", int'(bus.sched_state), 0);
    drain("hold");

    // start + over together in IDLE: stay IDLE
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_state("idle_start_over");

    // start + tick together: RUN, tick dropped (acc stays 0)
    base_moves = seen_moves;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_state("start_tick");
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(2);
    drain("start_tick");
    check("start_tick_moves", seen_moves - base_moves, 1);

    // over, then restart 50 ticks into the hold
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check_state("over2");
    tick_n(50);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check_state("restart");
    drain("restart");

    // reach level 3, then async reset during an in-flight move pulse
    tick_n(3 * LT);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("lvl3");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      if (m_pushed) break;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("lvl3_tick_moves", int'(m_pushed), 1);
    @(posedge clk);
    #1;
    check("inflight_pulse", int'(bus.move_pulse), 1);
    rst_n = 1'b0;
    #1;
    check("arst_move_pulse", int'(bus.move_pulse), 0);
    check("arst_state", int'(bus.sched_state), 0);
    check("arst_level", int'(bus.level), 0);
    check("arst_scroll_en", int'(bus.scroll_en), 0);
    check("arst_move_step", int'(bus.move_step), 0);
    sb_q.delete();
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick_n(5);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("post_rst");
    drain("post_rst");

`ifdef OBSTACLE_SCHED_PAUSE_EN
    // pause after 3 ticks (acc = 8), 30 ticks paused, resume: first tick moves
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check_state("p_start");
    tick_n(3);
    drain("p_pre");
    base_moves = seen_moves;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_state("pause");
    check("pause_enc_hand", int'(bus.sched_state), 3);
    tick_n(30);
    drain("paused");
    check("paused_moves", seen_moves - base_moves, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_state("resume");
    tick_n(1);
    drain("resume1");
    check("resume_moves", seen_moves - base_moves, 1);
    tick_n(3);
    drain("resume");
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_state("pause2");
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check_state("pause_over");
`endif

    drain("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
